input_buffer: RTL and testbench
===============================

INPUT_BUFFER -- requirements
Module: input_buffer

Interface
REQ-001 Parameter DEPTH, default 4, flit storage entries; legal values 2, 4, 8, 16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_  input  1  reset, asynchronous, active-low.
REQ-004 idata  input  `DATAW+1  incoming flit; top bits carry type field (`TYPE_HEAD/`TYPE_DATA/`TYPE_TAIL/`TYPE_NONE).
REQ-005 ivalid  input  1  idata/ivch valid this cycle.
REQ-006 ivch  input  `VCHW+1  virtual channel tag of incoming flit.
REQ-007 iready  output  1  buffer accepts a flit this cycle.
REQ-008 odata  output  `DATAW+1  head-of-queue flit, drives one mux data input.
REQ-009 ovalid  output  1  odata/ovch valid.
REQ-010 ovch  output  `VCHW+1  VC tag of head-of-queue flit.
REQ-011 ordy  input  1  downstream (mux/arbiter) consumes odata this cycle.
REQ-012 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-013 pkt_err  output  1  sticky packet-framing violation flag.

Function
REQ-014 Push when ivalid && iready; pop when ovalid && ordy; iready = (count < DEPTH) || pop in same cycle.
REQ-015 Circular storage, write/read pointers wrap DEPTH-1 -> 0.
REQ-016 Registered path: flit pushed in cycle N SHALL appear on odata/ovalid in cycle N+1 at the earliest.
REQ-017 Simultaneous push and pop when full: both occur, count unchanged, no flit lost.
REQ-018 Simultaneous push and pop when empty (bypass disabled): push occurs, pop ignored (ovalid was 0).
REQ-019 Pop when empty and push when full without same-cycle pop SHALL be impossible by REQ-014; state unchanged.
REQ-020 ovalid = (count != 0); odata/ovch = entry at read pointer, `TYPE_NONE with zero payload when empty.
REQ-021 Framing FSM on accepted flits, states IDLE and BODY: IDLE --HEAD--> BODY; BODY --TAIL--> IDLE; BODY --DATA--> BODY; HEAD+TAIL-type single-flit packets not supported.
REQ-022 DATA or TAIL accepted in IDLE, or HEAD accepted in BODY, SHALL set pkt_err next cycle; flit still stored; FSM moves per flit type (HEAD->BODY, TAIL->IDLE).
REQ-023 ivalid with `TYPE_NONE SHALL be dropped (not stored, no FSM change); iready unaffected.
REQ-024 pkt_err stays 1 until reset.

Reset
REQ-025 rst_ low: pointers 0, count 0, ovalid 0, odata `TYPE_NONE/zero, ovch 0, FSM IDLE, pkt_err 0, immediately without clock.
REQ-026 Reset mid-packet discards all stored flits; first accepted flit after release must be HEAD or pkt_err sets.
REQ-027 iready SHALL be 0 while rst_ is low.

Configuration
REQ-028 Macro INPUT_BUFFER_BYPASS_EN: when defined, a flit arriving while count==0 and ordy==1 SHALL pass combinationally idata->odata, ovalid=1 same cycle, not stored, FSM still updated; when undefined, REQ-016 latency of one cycle applies to every flit.

Verification
REQ-029 Reset then push HEAD, 20 DATA, TAIL with ordy=1 -> flits out in order, one-cycle latency (zero with bypass), pkt_err=0.
REQ-030 DEPTH=4, ordy=0, push 6 flits -> first 4 accepted, iready=0 after 4th, count=4; release ordy -> 4 flits out in order, count back to 0.
REQ-031 Full buffer, ordy=1 and ivalid=1 every cycle for 10 cycles -> count stays 4, 10 in/10 out, no loss or duplication.
REQ-032 Push DATA flit from IDLE -> pkt_err=1 next cycle, flit still delivered, pkt_err holds after later legal packets.
REQ-033 Assert rst_ low mid-packet with count=3 -> ovalid=0, count=0, iready=0 without clock edge; after release, HEAD accepted normally.
REQ-034 Inject 4/13 utilisation pattern (4 flits then 9 idle) for 10 packets with ordy toggling 1/0 -> output sequence equals input sequence minus `TYPE_NONE flits.

Source files
------------

// File: rtl/input_buffer.sv
// input_buffer: DEPTH-entry circular flit buffer with a packet-framing checker.
// Optional same-cycle bypass of an empty buffer when INPUT_BUFFER_BYPASS_EN is defined.
`ifndef DATAW
`define DATAW 31
`endif
`ifndef VCHW
`define VCHW 1
`endif
`ifndef TYPE_NONE
`define TYPE_NONE 2'b00
`endif
`ifndef TYPE_HEAD
`define TYPE_HEAD 2'b01
`endif
`ifndef TYPE_DATA
`define TYPE_DATA 2'b10
`endif
`ifndef TYPE_TAIL
`define TYPE_TAIL 2'b11
`endif

module input_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_,
    input  logic [`DATAW:0]          idata,
    input  logic                     ivalid,
    input  logic [`VCHW:0]           ivch,
    output logic                     iready,
    output logic [`DATAW:0]          odata,
    output logic                     ovalid,
    output logic [`VCHW:0]           ovch,
    input  logic                     ordy,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     pkt_err
);
    localparam int unsigned DW = `DATAW + 1;
    localparam int unsigned VW = `VCHW + 1;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned EW = DW + VW;

    typedef enum logic {
        IDLE = 1'b0,
        BODY = 1'b1
    } state_e;

    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    state_e        state_q, state_d;
    logic          pkt_err_q, pkt_err_d;

    logic [1:0]    itype_c;
    logic          stored_c;
    logic          pop_c;
    logic          accept_c;
    logic          bypass_c;
    logic          push_c;
    logic [EW-1:0] head_c;

    // Handshake, storage update, output selection and framing check.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        state_d   = state_q;
        pkt_err_d = pkt_err_q;

        itype_c  = idata[DW-1 -: 2];
        stored_c = (count_q != '0);
        pop_c    = stored_c && ordy;
        iready   = rst_ && ((count_q < CW'(DEPTH)) || pop_c);
        accept_c = ivalid && iready && (itype_c != `TYPE_NONE);
`ifdef INPUT_BUFFER_BYPASS_EN
        bypass_c = accept_c && !stored_c && ordy;
`else
        bypass_c = 1'b0;
`endif
        push_c   = accept_c && !bypass_c;

        head_c = mem_q[rd_ptr_q];
        ovalid = stored_c;
        odata  = stored_c ? head_c[EW-1:VW] : '0;
        ovch   = stored_c ? head_c[VW-1:0]  : '0;
        if (bypass_c) begin
            ovalid = 1'b1;
            odata  = idata;
            ovch   = ivch;
        end

        if (push_c) begin
            mem_d[wr_ptr_q] = {idata, ivch};
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop_c) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Violating flits are still stored; the FSM follows the flit type regardless.
        if (accept_c) begin
            unique case (itype_c)
                `TYPE_HEAD: begin
                    if (state_q == BODY) pkt_err_d = 1'b1;
                    state_d = BODY;
                end
                `TYPE_TAIL: begin
                    if (state_q == IDLE) pkt_err_d = 1'b1;
                    state_d = IDLE;
                end
                default: begin
                    if (state_q == IDLE) pkt_err_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= IDLE;
            pkt_err_q <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            pkt_err_q <= pkt_err_d;
        end
    end

    assign count   = count_q;
    assign pkt_err = pkt_err_q;

endmodule

// File: tb/tb_input_buffer.sv
// tb_input_buffer: directed scenarios for input_buffer checked against a queue model.
`timescale 1ns/1ps
`ifndef DATAW
`define DATAW 31
`endif
`ifndef VCHW
`define VCHW 1
`endif
`ifndef TYPE_NONE
`define TYPE_NONE 2'b00
`endif
`ifndef TYPE_HEAD
`define TYPE_HEAD 2'b01
`endif
`ifndef TYPE_DATA
`define TYPE_DATA 2'b10
`endif
`ifndef TYPE_TAIL
`define TYPE_TAIL 2'b11
`endif

module tb_input_buffer;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned DW    = `DATAW + 1;
    localparam int unsigned VW    = `VCHW + 1;
    localparam int unsigned PLW   = DW - 2;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;
    localparam int unsigned EW    = DW + VW;

    logic          clk = 1'b0;
    logic          rst_;
    logic [DW-1:0] idata;
    logic          ivalid;
    logic [VW-1:0] ivch;
    logic          iready;
    logic [DW-1:0] odata;
    logic          ovalid;
    logic [VW-1:0] ovch;
    logic          ordy;
    logic [CW-1:0] count;
    logic          pkt_err;

    int errors = 0;
    int checks = 0;

    logic [EW-1:0] sb [$];
    bit            m_body;
    bit            m_err;
    logic          exp_ready;
    logic          exp_ovalid;
    logic          exp_err;
    logic [DW-1:0] exp_odata;
    logic [VW-1:0] exp_ovch;
    logic [CW-1:0] exp_count;

    input_buffer #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst_    (rst_),
        .idata   (idata),
        .ivalid  (ivalid),
        .ivch    (ivch),
        .iready  (iready),
        .odata   (odata),
        .ovalid  (ovalid),
        .ovch    (ovch),
        .ordy    (ordy),
        .count   (count),
        .pkt_err (pkt_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // Drive one cycle at the falling edge and compute expectations from the model
    // state before the next rising edge; the model is then advanced for that edge.
    task automatic cyc(input logic [1:0] t, input logic [PLW-1:0] p, input logic v,
                       input logic [VW-1:0] vc, input logic r);
        logic          pop;
        logic          push;
        logic          byp;
        logic [DW-1:0] d;
        logic [EW-1:0] head;
        d = {t, p};
        @(negedge clk);
        idata  = d;
        ivalid = v;
        ivch   = vc;
        ordy   = r;
        #1;
        pop       = (sb.size() != 0) && r;
        exp_ready = (sb.size() < DEPTH) || pop;
        push      = v && exp_ready && (t != `TYPE_NONE);
        byp       = 1'b0;
`ifdef INPUT_BUFFER_BYPASS_EN
        byp       = push && (sb.size() == 0) && r;
`endif
        head       = (sb.size() != 0) ? sb[0] : '0;
        exp_ovalid = (sb.size() != 0) || byp;
        exp_odata  = byp ? d  : head[EW-1:VW];
        exp_ovch   = byp ? vc : head[VW-1:0];
        exp_count  = CW'(sb.size());
        exp_err    = m_err;
        if (pop) void'(sb.pop_front());
        if (push && !byp) sb.push_back({d, vc});
        if (push) begin
            case (t)
                `TYPE_HEAD: begin if (m_body) m_err = 1'b1; m_body = 1'b1; end
                `TYPE_TAIL: begin if (!m_body) m_err = 1'b1; m_body = 1'b0; end
                default:    begin if (!m_body) m_err = 1'b1; end
            endcase
        end
    endtask

    task automatic reset_high();
        @(negedge clk);
        ivalid = 1'b0;
        #2 rst_ = 1'b1;
    endtask

    task automatic test_reset();
        rst_   = 1'b0;
        idata  = {`TYPE_HEAD, PLW'(0)};
        ivalid = 1'b1;
        ivch   = '0;
        ordy   = 1'b1;
        sb.delete();
        m_body = 1'b0;
        m_err  = 1'b0;
        #1;
        checks += 6;
        if (ovalid !== 1'b0)  begin errors++; $display("FAIL reset ovalid: got %b want 0", ovalid); end
        if (count !== '0)     begin errors++; $display("FAIL reset count: got %0d want 0", count); end
        if (iready !== 1'b0)  begin errors++; $display("FAIL reset iready: got %b want 0", iready); end
        if (odata !== '0)     begin errors++; $display("FAIL reset odata: got %h want 0", odata); end
        if (ovch !== '0)      begin errors++; $display("FAIL reset ovch: got %h want 0", ovch); end
        if (pkt_err !== 1'b0) begin errors++; $display("FAIL reset pkt_err: got %b want 0", pkt_err); end
        reset_high();
    endtask

    // HEAD, 20 DATA, TAIL streamed with ordy held high.
    task automatic test_stream();
        for (int i = 0; i < 25; i++) begin
            logic [1:0] t;
            t = (i == 0) ? `TYPE_HEAD : (i == 21) ? `TYPE_TAIL : (i < 21) ? `TYPE_DATA : `TYPE_NONE;
            cyc(t, PLW'(32'h100 + i), (i < 22), VW'(i % 4), 1'b1);
            checks += 3;
            if (ovalid !== exp_ovalid) begin errors++; $display("FAIL stream ovalid[%0d]: got %b want %b", i, ovalid, exp_ovalid); end
            if ({odata, ovch} !== {exp_odata, exp_ovch}) begin
                errors++; $display("FAIL stream odata[%0d]: got %h/%h want %h/%h", i, odata, ovch, exp_odata, exp_ovch);
            end
            if (pkt_err !== exp_err) begin errors++; $display("FAIL stream pkt_err[%0d]: got %b want %b", i, pkt_err, exp_err); end
        end
    endtask

    // Fill with ordy low, verify backpressure, then drain in order.
    task automatic test_fill();
        for (int i = 0; i < 6; i++) begin
            cyc((i == 0) ? `TYPE_HEAD : `TYPE_DATA, PLW'(32'h200 + i), 1'b1, VW'(1), 1'b0);
            checks += 2;
            if (iready !== exp_ready) begin errors++; $display("FAIL fill iready[%0d]: got %b want %b", i, iready, exp_ready); end
            if (count !== exp_count)  begin errors++; $display("FAIL fill count[%0d]: got %0d want %0d", i, count, exp_count); end
        end
        cyc(`TYPE_NONE, '0, 1'b0, '0, 1'b0);
        checks++;
        if (count !== CW'(DEPTH)) begin errors++; $display("FAIL fill full count: got %0d want %0d", count, DEPTH); end
        for (int i = 0; i < 6; i++) begin
            cyc(`TYPE_NONE, '0, 1'b0, '0, 1'b1);
            checks += 2;
            if (ovalid !== exp_ovalid) begin errors++; $display("FAIL fill drain ovalid[%0d]: got %b want %b", i, ovalid, exp_ovalid); end
            if ({odata, ovch} !== {exp_odata, exp_ovch}) begin
                errors++; $display("FAIL fill drain odata[%0d]: got %h want %h", i, odata, exp_odata);
            end
        end
        checks++;
        if (count !== '0) begin errors++; $display("FAIL fill empty count: got %0d want 0", count); end
        cyc(`TYPE_TAIL, PLW'(32'h2ff), 1'b1, VW'(1), 1'b1);
        cyc(`TYPE_NONE, '0, 1'b0, '0, 1'b1);
        checks++;
        if ({odata, ovalid} !== {exp_odata, exp_ovalid}) begin
            errors++; $display("FAIL fill tail odata: got %h/%b want %h/%b", odata, ovalid, exp_odata, exp_ovalid);
        end
    endtask

    // Full buffer with push and pop every cycle for 10 cycles.
    task automatic test_full_throughput();
        int in_n  = 0;
        int out_n = 0;
        for (int i = 0; i < 4; i++) begin
            cyc((i == 0) ? `TYPE_HEAD : `TYPE_DATA, PLW'(32'h300 + i), 1'b1, VW'(2), 1'b0);
        end
        for (int i = 0; i < 10; i++) begin
            cyc(`TYPE_DATA, PLW'(32'h310 + i), 1'b1, VW'(2), 1'b1);
            if (ivalid && iready) in_n++;
            if (ovalid && ordy) out_n++;
            checks += 3;
            if (count !== exp_count)  begin errors++; $display("FAIL full count[%0d]: got %0d want %0d", i, count, exp_count); end
            if (iready !== exp_ready) begin errors++; $display("FAIL full iready[%0d]: got %b want %b", i, iready, exp_ready); end
            if (odata !== exp_odata)  begin errors++; $display("FAIL full odata[%0d]: got %h want %h", i, odata, exp_odata); end
        end
        checks += 2;
        if (in_n !== 10)  begin errors++; $display("FAIL full pushes: got %0d want 10", in_n); end
        if (out_n !== 10) begin errors++; $display("FAIL full pops: got %0d want 10", out_n); end
        cyc(`TYPE_TAIL, PLW'(32'h3ff), 1'b1, VW'(2), 1'b1);
        for (int i = 0; i < 6; i++) begin
            cyc(`TYPE_NONE, '0, 1'b0, '0, 1'b1);
            checks++;
            if ({odata, ovalid} !== {exp_odata, exp_ovalid}) begin
                errors++; $display("FAIL full drain[%0d]: got %h/%b want %h/%b", i, odata, ovalid, exp_odata, exp_ovalid);
            end
        end
    endtask

    // DATA from IDLE flags an error that survives a later legal packet.
    task automatic test_framing_err();
        logic [1:0] ts [8];
        logic       vs [8];
        ts = '{`TYPE_DATA, `TYPE_NONE, `TYPE_NONE, `TYPE_HEAD, `TYPE_DATA, `TYPE_TAIL, `TYPE_NONE, `TYPE_NONE};
        vs = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            cyc(ts[i], PLW'(32'h400 + i), vs[i], VW'(3), 1'b1);
            checks += 2;
            if (pkt_err !== exp_err) begin errors++; $display("FAIL framing pkt_err[%0d]: got %b want %b", i, pkt_err, exp_err); end
            if ({odata, ovalid} !== {exp_odata, exp_ovalid}) begin
                errors++; $display("FAIL framing odata[%0d]: got %h/%b want %h/%b", i, odata, ovalid, exp_odata, exp_ovalid);
            end
        end
        checks++;
        if (pkt_err !== 1'b1) begin errors++; $display("FAIL framing sticky: got %b want 1", pkt_err); end
    endtask

    // Asynchronous reset with three flits stored, then a clean packet.
    task automatic test_reset_midpacket();
        for (int i = 0; i < 3; i++) begin
            cyc((i == 0) ? `TYPE_HEAD : `TYPE_DATA, PLW'(32'h500 + i), 1'b1, VW'(0), 1'b0);
        end
        @(negedge clk);
        ordy = 1'b1;
        #1;
        checks++;
        if (count !== CW'(3)) begin errors++; $display("FAIL midrst pre count: got %0d want 3", count); end
        #1 rst_ = 1'b0;
        sb.delete();
        m_body = 1'b0;
        m_err  = 1'b0;
        #1;
        checks += 4;
        if (ovalid !== 1'b0)  begin errors++; $display("FAIL midrst ovalid: got %b want 0", ovalid); end
        if (count !== '0)     begin errors++; $display("FAIL midrst count: got %0d want 0", count); end
        if (iready !== 1'b0)  begin errors++; $display("FAIL midrst iready: got %b want 0", iready); end
        if (pkt_err !== 1'b0) begin errors++; $display("FAIL midrst pkt_err: got %b want 0", pkt_err); end
        reset_high();
        for (int i = 0; i < 5; i++) begin
            logic [1:0] t;
            t = (i == 0) ? `TYPE_HEAD : (i == 1) ? `TYPE_DATA : (i == 2) ? `TYPE_TAIL : `TYPE_NONE;
            cyc(t, PLW'(32'h510 + i), (i < 3), VW'(1), 1'b1);
            checks += 2;
            if (pkt_err !== exp_err) begin errors++; $display("FAIL midrst post pkt_err[%0d]: got %b want %b", i, pkt_err, exp_err); end
            if ({odata, ovalid} !== {exp_odata, exp_ovalid}) begin
                errors++; $display("FAIL midrst post odata[%0d]: got %h/%b want %h/%b", i, odata, ovalid, exp_odata, exp_ovalid);
            end
        end
    endtask

    // 4 flits then 9 idle cycles per packet, idle cycles carrying TYPE_NONE on odd slots.
    task automatic test_utilisation();
        int n = 0;
        for (int pkt = 0; pkt < 10; pkt++) begin
            for (int j = 0; j < 13; j++) begin
                logic [1:0] t;
                logic       v;
                t = (j == 0) ? `TYPE_HEAD : (j == 3) ? `TYPE_TAIL : (j < 3) ? `TYPE_DATA : `TYPE_NONE;
                v = (j < 4) || (j % 2 == 1);
                cyc(t, PLW'(32'h1000 + pkt * 16 + j), v, VW'(pkt % 4), n[0]);
                n++;
                checks += 3;
                if (iready !== exp_ready) begin errors++; $display("FAIL util iready[%0d]: got %b want %b", n, iready, exp_ready); end
                if (count !== exp_count)  begin errors++; $display("FAIL util count[%0d]: got %0d want %0d", n, count, exp_count); end
                if ({odata, ovch, ovalid} !== {exp_odata, exp_ovch, exp_ovalid}) begin
                    errors++; $display("FAIL util odata[%0d]: got %h/%h/%b want %h/%h/%b", n, odata, ovch, ovalid, exp_odata, exp_ovch, exp_ovalid);
                end
            end
        end
        for (int i = 0; i < 6; i++) begin
            cyc(`TYPE_NONE, '0, 1'b0, '0, 1'b1);
        end
        checks += 2;
        if (count !== '0)     begin errors++; $display("FAIL util final count: got %0d want 0", count); end
        if (pkt_err !== 1'b0) begin errors++; $display("FAIL util pkt_err: got %b want 0", pkt_err); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_fill();
        test_full_throughput();
        test_framing_err();
        test_reset_midpacket();
        test_utilisation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
